// File: rtl/zpu_irq_pkg.sv
// Shared definitions for the ZPU vectored interrupt controller: register map,
// request FSM encoding and the byte-lane merge used by every writable register.
package zpu_irq_pkg;

    localparam logic [5:0] REG_ENABLE  = 6'h00;
    localparam logic [5:0] REG_PENDING = 6'h01;
    localparam logic [5:0] REG_EDGE    = 6'h02;
    localparam logic [5:0] REG_ACTIVE  = 6'h03;
    localparam logic [5:0] REG_NEST    = 6'h04;
    localparam logic [5:0] REG_VECTOR  = 6'h10;

    localparam logic [4:0] IDLE_ID = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD
    } irq_state_e;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] wb_merge(input logic [31:0] old_val,
                                             input logic [31:0] wr_val,
                                             input logic [3:0]  sel);
        return (old_val & ~byte_mask(sel)) | (wr_val & byte_mask(sel));
    endfunction

endpackage

// File: rtl/zpu_irq_prio_enc.sv
// Fixed-priority encoder, lowest index wins; purely combinational, no backpressure.
module zpu_irq_prio_enc #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               vld,
    output logic [4:0]         id
);

    always_comb begin
        vld = 1'b0;
        id  = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                id  = 5'(i);
            end
        end
    end

endmodule

// File: rtl/zpu_irq_ctrl.sv
// Nested vectored interrupt controller for the ZPU core; edge-to-cpu_irq latency 2 cycles.
// Wishbone slave never stalls and acks every accepted access one cycle later.
module zpu_irq_ctrl
    import zpu_irq_pkg::*;
#(
    parameter int NUM_IRQ           = 8,
    parameter int pc_bit_size       = 25,
    parameter int MAX_NEST          = 4,
    parameter int RESET_VECTOR_BASE = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_IRQ-1:0]     irq_src,
    input  logic [7:0]             wb_adr,
    input  logic [31:0]            wb_in,
    output logic [31:0]            wb_out,
    input  logic [3:0]             wb_sel,
    input  logic                   wb_we,
    input  logic                   wb_cyc,
    input  logic                   wb_stb,
    output logic                   wb_ack,
    output logic                   wb_stall,
    output logic                   cpu_irq,
    output logic [pc_bit_size-1:0] interuptadr,
    input  logic                   interrutack,
    input  logic                   exitint,
    output logic [4:0]             active_id
);

    logic                   accept, wr_en, push, pop, win_ok;
    logic [5:0]             wb_word;
    logic                   unused_adr;
    logic [NUM_IRQ-1:0]     enable_q, enable_d, edge_q, edge_d, irq_prev_q;
    logic [NUM_IRQ-1:0]     pend_edge_q, pend_edge_d, active_q, active_d;
    logic [NUM_IRQ-1:0]     pending, eligible, prio_mask, rise, w1c, ack_clr;
    logic [4:0]             stack_q [MAX_NEST];
    logic [4:0]             stack_d [MAX_NEST];
    logic [3:0]             nest_q, nest_d;
    logic [pc_bit_size-1:0] vector_q [NUM_IRQ];
    logic [pc_bit_size-1:0] vector_d [NUM_IRQ];
    logic [4:0]             top_id, enc_id, win_id_q;
    logic                   enc_vld;
    logic [pc_bit_size-1:0] enc_vector, interuptadr_q;
    irq_state_e             state_q;
    logic                   cpu_irq_q, wb_ack_q;
    logic [31:0]            wb_out_q, wb_out_d, rd_dat;

    assign accept     = wb_cyc & wb_stb;
    assign wr_en      = accept & wb_we;
    assign wb_word    = wb_adr[7:2];
    assign unused_adr = ^wb_adr[1:0];

    always_comb begin
        top_id = IDLE_ID;
        for (int k = 0; k < MAX_NEST; k++) begin
            if (nest_q == 4'(k + 1)) top_id = stack_q[k];
        end
    end

    // Only channels strictly more urgent than the one in service may pre-empt it.
    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            prio_mask[i] = (nest_q == 4'd0) || (5'(i) < top_id);
        end
    end

    assign pending  = (pend_edge_q & edge_q) | (irq_src & ~edge_q);
    assign eligible = (nest_q == 4'(MAX_NEST)) ? '0
                    : (pending & enable_q & ~active_q & prio_mask);
    assign win_ok   = |(eligible & (NUM_IRQ'(1) << win_id_q));

    zpu_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
        .req (eligible),
        .vld (enc_vld),
        .id  (enc_id)
    );

    always_comb begin
        enc_vector = '0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            if (5'(n) == enc_id) enc_vector = vector_q[n];
        end
    end

    assign push = (state_q == ST_REQ) && interrutack;
    assign pop  = exitint && (nest_q != 4'd0);

    // A same-cycle return and accept pops first so the new channel lands on the freed slot.
    always_comb begin
        stack_d  = stack_q;
        active_d = active_q;
        nest_d   = nest_q;
        if (pop) begin
            nest_d = nest_q - 4'd1;
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (5'(i) == top_id) active_d[i] = 1'b0;
            end
        end
        if (push) begin
            for (int k = 0; k < MAX_NEST; k++) begin
                if (4'(k) == nest_d) stack_d[k] = win_id_q;
            end
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (5'(i) == win_id_q) active_d[i] = 1'b1;
            end
            nest_d = nest_d + 4'd1;
        end
    end

    assign rise    = irq_src & ~irq_prev_q & edge_q;
    assign w1c     = (wr_en && wb_word == REG_PENDING) ? NUM_IRQ'(wb_in & byte_mask(wb_sel)) : '0;
    assign ack_clr = push ? (NUM_IRQ'(1) << win_id_q) : '0;

    always_comb begin
        pend_edge_d = (pend_edge_q & ~w1c & ~ack_clr) | rise;
        enable_d    = enable_q;
        edge_d      = edge_q;
        vector_d    = vector_q;
        if (wr_en && wb_word == REG_ENABLE) enable_d = NUM_IRQ'(wb_merge(32'(enable_q), wb_in, wb_sel));
        if (wr_en && wb_word == REG_EDGE)   edge_d   = NUM_IRQ'(wb_merge(32'(edge_q), wb_in, wb_sel));
        for (int n = 0; n < NUM_IRQ; n++) begin
            if (wr_en && wb_word == REG_VECTOR + 6'(n)) begin
                vector_d[n] = pc_bit_size'(wb_merge(32'(vector_q[n]), wb_in, wb_sel));
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        case (wb_word)
            REG_ENABLE:  rd_dat = 32'(enable_q);
            REG_PENDING: rd_dat = 32'(pending);
            REG_EDGE:    rd_dat = 32'(edge_q);
            REG_ACTIVE:  rd_dat = 32'(active_q);
            REG_NEST:    rd_dat = 32'(nest_q);
            default: begin
                for (int n = 0; n < NUM_IRQ; n++) begin
                    if (wb_word == REG_VECTOR + 6'(n)) rd_dat = 32'(vector_q[n]);
                end
            end
        endcase
        wb_out_d = (accept && !wb_we) ? rd_dat : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q    <= '0;
            edge_q      <= '0;
            irq_prev_q  <= '0;
            pend_edge_q <= '0;
            active_q    <= '0;
            nest_q      <= '0;
            wb_ack_q    <= 1'b0;
            wb_out_q    <= '0;
            for (int k = 0; k < MAX_NEST; k++) stack_q[k] <= '0;
            for (int n = 0; n < NUM_IRQ; n++) vector_q[n] <= pc_bit_size'(RESET_VECTOR_BASE + 32 * n);
        end else begin
            enable_q    <= enable_d;
            edge_q      <= edge_d;
            irq_prev_q  <= irq_src;
            pend_edge_q <= pend_edge_d;
            active_q    <= active_d;
            nest_q      <= nest_d;
            wb_ack_q    <= accept;
            wb_out_q    <= wb_out_d;
            stack_q     <= stack_d;
            vector_q    <= vector_d;
        end
    end

    // The vector is captured at request time so software rewrites cannot glitch an open request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            win_id_q      <= '0;
            cpu_irq_q     <= 1'b0;
            interuptadr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enc_vld) begin
                        state_q       <= ST_REQ;
                        win_id_q      <= enc_id;
                        interuptadr_q <= enc_vector;
                        cpu_irq_q     <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (interrutack) begin
                        state_q   <= ST_HOLD;
                        cpu_irq_q <= 1'b0;
                    end else if (!win_ok) begin
                        state_q   <= ST_IDLE;
                        cpu_irq_q <= 1'b0;
                    end
                end
                ST_HOLD: state_q <= ST_IDLE;
                default: begin
                    state_q   <= ST_IDLE;
                    cpu_irq_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_irq     = cpu_irq_q;
    assign interuptadr = interuptadr_q;
    assign wb_ack      = wb_ack_q;
    assign wb_out      = wb_out_q;
    assign wb_stall    = 1'b0;
    assign active_id   = top_id;

endmodule

// File: tb/tb_zpu_irq_ctrl.sv
// Directed bench for zpu_irq_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_zpu_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic [7:0]  wb_adr;
    logic [31:0] wb_in, wb_out;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_stall;
    logic        cpu_irq;
    logic [24:0] interuptadr;
    logic        interrutack, exitint;
    logic [4:0]  active_id;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       name_q[$];
    int          sig_sel_q[$];
    logic [31:0] sig_exp_q[$];
    string       sig_name_q[$];

    zpu_irq_ctrl #(
        .NUM_IRQ(8), .pc_bit_size(25), .MAX_NEST(2), .RESET_VECTOR_BASE(32)
    ) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src),
        .wb_adr(wb_adr), .wb_in(wb_in), .wb_out(wb_out), .wb_sel(wb_sel),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_ack(wb_ack), .wb_stall(wb_stall),
        .cpu_irq(cpu_irq), .interuptadr(interuptadr), .interrutack(interrutack),
        .exitint(exitint), .active_id(active_id)
    );

    always #5 clk = ~clk;

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] e);
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, e);
        end
    endtask

    always @(negedge clk) begin : monitor
        int          sel;
        logic [31:0] act;
        logic [31:0] e;
        string       nm;
        bit          c;
        while (sig_sel_q.size() > 0) begin
            sel = sig_sel_q.pop_front();
            e   = sig_exp_q.pop_front();
            nm  = sig_name_q.pop_front();
            case (sel)
                0:       act = 32'(cpu_irq);
                1:       act = 32'(interuptadr);
                2:       act = 32'(active_id);
                3:       act = 32'(wb_ack);
                4:       act = wb_out;
                6:       act = 32'(wb_stall);
                default: act = 32'(exp_q.size());
            endcase
            cmp(nm, act, e);
        end
        if (wb_ack) begin
            if (exp_q.size() == 0) begin
                cmp("spurious_ack", 32'(wb_ack), 32'd0);
            end else begin
                e  = exp_q.pop_front();
                c  = chk_q.pop_front();
                nm = name_q.pop_front();
                if (c) cmp(nm, wb_out, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(int sel, logic [31:0] e, string nm);
        sig_sel_q.push_back(sel);
        sig_exp_q.push_back(e);
        sig_name_q.push_back(nm);
    endtask

    task automatic wb_write(logic [7:0] a, logic [31:0] d, logic [3:0] s);
        exp_q.push_back(32'd0);
        chk_q.push_back(1'b0);
        name_q.push_back("write");
        wb_adr = a; wb_in = d; wb_sel = s; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();
        wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic wb_read(logic [7:0] a, logic [31:0] e, string nm);
        exp_q.push_back(e);
        chk_q.push_back(1'b1);
        name_q.push_back(nm);
        wb_adr = a; wb_sel = 4'hF; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    // Edge pulse on ch, expect the request two cycles later, accept it and sit out HOLD.
    task automatic take(int ch, logic [31:0] vec);
        irq_src[ch] = 1'b1;
        tick();
        irq_src[ch] = 1'b0;
        expect_sig(0, 32'd0, "take_irq_early");
        tick();
        expect_sig(0, 32'd1, "take_irq_t2");
        expect_sig(1, vec, "take_vector");
        interrutack = 1'b1;
        tick();
        interrutack = 1'b0;
        expect_sig(2, 32'(ch), "take_active_id");
        expect_sig(0, 32'd0, "take_hold_low");
        tick();
    endtask

    initial begin
        rst = 1'b0; irq_src = '0; wb_adr = '0; wb_in = '0; wb_sel = '0;
        wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; interrutack = 1'b0; exitint = 1'b0;
        tick();
        expect_sig(0, 32'd0, "rst_cpu_irq");
        expect_sig(1, 32'd0, "rst_interuptadr");
        expect_sig(2, 32'd31, "rst_active_id");
        expect_sig(3, 32'd0, "rst_wb_ack");
        expect_sig(4, 32'd0, "rst_wb_out");
        expect_sig(6, 32'd0, "wb_stall");
        tick();
        rst = 1'b1;
        tick();
        wb_read(8'h4C, 32'd128, "vector3_reset");
        wb_read(8'h00, 32'd0, "enable_reset");
        wb_read(8'h10, 32'd0, "nest_reset");

        wb_write(8'h00, 32'h05, 4'hF);
        wb_write(8'h08, 32'h05, 4'hF);
        wb_read(8'h08, 32'h05, "edge_readback");
        take(2, 32'd96);
        wb_read(8'h04, 32'h00, "pending_after_ack");
        wb_read(8'h0C, 32'h04, "active_ch2");
        wb_read(8'h10, 32'd1, "nest_one");

        take(0, 32'd32);
        wb_read(8'h10, 32'd2, "nest_two");
        wb_read(8'h0C, 32'h05, "active_ch0_ch2");
        exitint = 1'b1; tick(); exitint = 1'b0;
        expect_sig(2, 32'd2, "pop_to_ch2");
        exitint = 1'b1; tick(); exitint = 1'b0;
        expect_sig(2, 32'd31, "pop_to_idle");
        wb_read(8'h0C, 32'h00, "active_empty");
        wb_read(8'h10, 32'd0, "nest_empty");

        wb_write(8'h00, 32'h15, 4'hF);
        wb_write(8'h08, 32'h15, 4'hF);
        take(2, 32'd96);
        irq_src[4] = 1'b1; tick(); irq_src[4] = 1'b0;
        tick();
        expect_sig(0, 32'd0, "ch4_blocked_a");
        tick();
        expect_sig(0, 32'd0, "ch4_blocked_b");
        wb_read(8'h04, 32'h10, "ch4_pending");
        exitint = 1'b1; tick(); exitint = 1'b0;
        expect_sig(0, 32'd0, "ch4_after_exit_a");
        tick();
        expect_sig(0, 32'd1, "ch4_after_exit_b");
        expect_sig(1, 32'd160, "ch4_vector");
        interrutack = 1'b1; tick(); interrutack = 1'b0;
        expect_sig(2, 32'd4, "ch4_active_id");
        tick();
        exitint = 1'b1; tick(); exitint = 1'b0;

        wb_write(8'h00, 32'h17, 4'hF);
        irq_src[1] = 1'b1;
        tick();
        expect_sig(0, 32'd1, "level_req");
        expect_sig(1, 32'd64, "level_vector");
        irq_src[1] = 1'b0;
        tick();
        expect_sig(0, 32'd0, "level_dropped");
        tick();
        expect_sig(0, 32'd0, "level_stays_idle");
        wb_read(8'h0C, 32'h00, "level_no_active");
        wb_read(8'h10, 32'd0, "level_no_nest");

        take(2, 32'd96);
        irq_src[1] = 1'b1;
        tick();
        expect_sig(0, 32'd1, "nest_ch1_req");
        expect_sig(1, 32'd64, "nest_ch1_vector");
        interrutack = 1'b1; tick(); interrutack = 1'b0;
        irq_src[1] = 1'b0;
        expect_sig(2, 32'd1, "nest_ch1_active");
        tick();
        irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
        tick();
        expect_sig(0, 32'd0, "maxnest_block_a");
        tick();
        expect_sig(0, 32'd0, "maxnest_block_b");
        wb_read(8'h10, 32'd2, "maxnest_depth");
        exitint = 1'b1; tick(); exitint = 1'b0;
        expect_sig(0, 32'd0, "maxnest_exit_a");
        expect_sig(2, 32'd2, "maxnest_exit_top");
        tick();
        expect_sig(0, 32'd1, "maxnest_exit_req");
        expect_sig(1, 32'd32, "maxnest_exit_vector");
        interrutack = 1'b1; exitint = 1'b1;
        tick();
        interrutack = 1'b0; exitint = 1'b0;
        expect_sig(2, 32'd0, "swap_top");
        tick();
        wb_read(8'h10, 32'd1, "swap_nest");
        wb_read(8'h0C, 32'h01, "swap_active");
        exitint = 1'b1; tick(); exitint = 1'b0;

        wb_write(8'h00, 32'h16, 4'hF);
        irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
        tick();
        irq_src[0] = 1'b1;
        wb_write(8'h04, 32'h01, 4'hF);
        irq_src[0] = 1'b0;
        wb_read(8'h04, 32'h01, "set_beats_w1c");
        wb_write(8'h04, 32'h01, 4'hF);
        wb_read(8'h04, 32'h00, "w1c_clears");

        wb_write(8'h54, 32'hAABBCCDD, 4'b0010);
        wb_read(8'h54, 32'h0000CCC0, "vector5_bytesel");
        wb_write(8'h58, 32'hFFFFFFFF, 4'hF);
        wb_read(8'h58, 32'h01FFFFFF, "vector6_width");
        wb_read(8'h20, 32'h00000000, "unmapped_read");

        tick();
        expect_sig(5, 32'd0, "scoreboard_drained");
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
